// File: rtl/arb_grant_fifo.sv
// arb_grant_fifo: captures the arbiter's granted requester (data + ID) into a
// small first-word-fall-through FIFO, presents the head over valid/ready,
// returns a one-cycle Ack per stored grant and keeps sticky protocol errors.
module arb_grant_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             Grant,
   input  logic [4*DW-1:0]        Req_Data,
   output logic                   Out_Valid,
   input  logic                   Out_Ready,
   output logic [DW-1:0]          Out_Data,
   output logic [1:0]             Out_Id,
   output logic [3:0]             Ack,
   output logic [$clog2(DEPTH):0] Count,
   output logic                   Full,
   output logic                   Err_Multi_Grant,
   output logic                   Err_Overflow,
   input  logic                   Err_Clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem_data [DEPTH];
   logic [1:0]    mem_id   [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [3:0]    ack_q;
   logic          err_multi_q;
   logic          err_ovf_q;

   logic          grant_multi;
   logic          grant_one;
   logic [1:0]    grant_id;
   logic [DW-1:0] grant_data;
   logic          pop;
   logic          push;
   logic          ovf_event;

   // Classify the grant and select the granted requester's ID and data slice
   always_comb begin
      grant_id    = 2'd0;
      grant_data  = '0;
      grant_multi = (Grant & (Grant - 4'd1)) != 4'd0;
      grant_one   = (Grant != 4'd0) && !grant_multi;
      for (int i = 0; i < 4; i++) begin
         if (Grant[i]) begin
            grant_id   = 2'(i);
            grant_data = Req_Data[i*DW +: DW];
         end
      end
   end

   // A full FIFO still accepts a push when the head leaves on the same edge
   always_comb begin
      pop       = Out_Valid && Out_Ready;
      push      = grant_one && (!Full || pop);
      ovf_event = grant_one && Full && !pop;
   end

   // Storage array; contents need no reset because validity comes from count_q
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= grant_data;
         mem_id[wr_ptr]   <= grant_id;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Ack pulse one cycle after acceptance; sticky errors where a new event beats a clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q       <= '0;
         err_multi_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         ack_q       <= push ? Grant : 4'd0;
         err_multi_q <= grant_multi || (err_multi_q && !Err_Clr);
         err_ovf_q   <= ovf_event || (err_ovf_q && !Err_Clr);
      end
   end

   assign Out_Valid       = (count_q != '0);
   assign Out_Data        = mem_data[rd_ptr];
   assign Out_Id          = mem_id[rd_ptr];
   assign Count           = count_q;
   assign Full            = (count_q == CW'(DEPTH));
   assign Ack             = ack_q;
   assign Err_Multi_Grant = err_multi_q;
   assign Err_Overflow    = err_ovf_q;

endmodule

// File: tb/tb_arb_grant_fifo.sv
// Bench for arb_grant_fifo: a queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_arb_grant_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    Grant = '0;
   logic [4*DW-1:0] Req_Data = '0;
   logic          Out_Ready = 1'b0;
   logic          Err_Clr = 1'b0;
   logic          Out_Valid;
   logic [DW-1:0] Out_Data;
   logic [1:0]    Out_Id;
   logic [3:0]    Ack;
   logic [2:0]    Count;
   logic          Full;
   logic          Err_Multi_Grant;
   logic          Err_Overflow;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: queue of {id, data}
   logic [DW+1:0] q[$];
   logic [3:0]    m_ack = '0;
   logic          m_em = 1'b0;
   logic          m_eo = 1'b0;

   arb_grant_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .Grant(Grant), .Req_Data(Req_Data),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
      .Out_Id(Out_Id), .Ack(Ack), .Count(Count), .Full(Full),
      .Err_Multi_Grant(Err_Multi_Grant), .Err_Overflow(Err_Overflow),
      .Err_Clr(Err_Clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model update from the rules: classify grant, pop head, push if room
   always @(posedge clk or negedge rst_n) begin
      int  nh;
      bit  do_pop, do_push, em_ev, eo_ev;
      if (!rst_n) begin
         q.delete();
         m_ack = '0;
         m_em  = 1'b0;
         m_eo  = 1'b0;
      end else begin
         nh      = $countones(Grant);
         do_pop  = (q.size() != 0) && Out_Ready;
         em_ev   = (nh > 1);
         do_push = 1'b0;
         eo_ev   = 1'b0;
         if (nh == 1) begin
            if (q.size() < DEPTH || do_pop) do_push = 1'b1;
            else eo_ev = 1'b1;
         end
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            for (int i = 0; i < 4; i++)
               if (Grant[i]) q.push_back({2'(i), Req_Data[i*DW +: DW]});
         end
         m_ack = do_push ? Grant : 4'd0;
         m_em  = em_ev ? 1'b1 : (Err_Clr ? 1'b0 : m_em);
         m_eo  = eo_ev ? 1'b1 : (Err_Clr ? 1'b0 : m_eo);
      end
   end

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("valid", 32'(Out_Valid), 32'(q.size() != 0));
      chk("count", 32'(Count), 32'(q.size()));
      chk("full", 32'(Full), 32'(q.size() == DEPTH));
      chk("ack", 32'(Ack), 32'(m_ack));
      chk("err_multi", 32'(Err_Multi_Grant), 32'(m_em));
      chk("err_ovf", 32'(Err_Overflow), 32'(m_eo));
      if (q.size() != 0) begin
         chk("data", 32'(Out_Data), 32'(q[0][DW-1:0]));
         chk("id", 32'(Out_Id), 32'(q[0][DW+1:DW]));
      end
   end

   task automatic tick(input logic [3:0] g, input logic [31:0] d, input logic rdy, input logic clr);
      Grant     = g;
      Req_Data  = d;
      Out_Ready = rdy;
      Err_Clr   = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_head(input string name, input logic [7:0] d, input logic [1:0] id);
      chk({name, "_valid"}, 32'(Out_Valid), 32'd1);
      chk({name, "_data"}, 32'(Out_Data), 32'(d));
      chk({name, "_id"}, 32'(Out_Id), 32'(id));
   endtask

   logic [3:0] stab_g [5] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100};

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_valid", 32'(Out_Valid), 32'd0);
      chk("rst_count", 32'(Count), 32'd0);
      chk("rst_full", 32'(Full), 32'd0);
      chk("rst_ack", 32'(Ack), 32'd0);

      // single grant into empty FIFO
      tick(4'b0001, 32'h000000A5, 1'b0, 1'b0);
      chk("t1_ack", 32'(Ack), 32'h1);
      chk_head("t1", 8'hA5, 2'd0);
      chk("t1_count", 32'(Count), 32'd1);
      tick(4'b0000, 32'h0, 1'b1, 1'b0);
      chk("t1_pop_count", 32'(Count), 32'd0);
      chk("t1_pop_ack", 32'(Ack), 32'd0);

      // fill with one grant per requester
      tick(4'b0001, 32'h13121110, 1'b0, 1'b0);
      tick(4'b0010, 32'h13121110, 1'b0, 1'b0);
      tick(4'b0100, 32'h13121110, 1'b0, 1'b0);
      tick(4'b1000, 32'h13121110, 1'b0, 1'b0);
      chk("fill_count", 32'(Count), 32'd4);
      chk("fill_full", 32'(Full), 32'd1);
      chk_head("fill", 8'h10, 2'd0);

      // overflow while full and stalled
      tick(4'b0100, 32'h13121110, 1'b0, 1'b0);
      chk("ovf_ack", 32'(Ack), 32'd0);
      chk("ovf_err", 32'(Err_Overflow), 32'd1);
      chk("ovf_count", 32'(Count), 32'd4);
      tick(4'b0000, 32'h0, 1'b0, 1'b1);
      chk("ovf_clr", 32'(Err_Overflow), 32'd0);

      // full with simultaneous pop: push accepted
      tick(4'b0100, 32'h13121110, 1'b1, 1'b0);
      chk("pp_ack", 32'(Ack), 32'b0100);
      chk("pp_count", 32'(Count), 32'd4);
      chk("pp_err", 32'(Err_Overflow), 32'd0);
      chk_head("pp", 8'h11, 2'd1);

      // drain in grant order
      tick(4'b0000, 32'h0, 1'b1, 1'b0);
      chk_head("dr1", 8'h12, 2'd2);
      tick(4'b0000, 32'h0, 1'b1, 1'b0);
      chk_head("dr2", 8'h13, 2'd3);
      tick(4'b0000, 32'h0, 1'b1, 1'b0);
      chk_head("dr3", 8'h12, 2'd2);
      tick(4'b0000, 32'h0, 1'b1, 1'b0);
      chk("dr_empty", 32'(Out_Valid), 32'd0);

      // multi-hot grant and sticky clear priority
      tick(4'b0011, 32'h44332211, 1'b0, 1'b0);
      chk("mg_ack", 32'(Ack), 32'd0);
      chk("mg_err", 32'(Err_Multi_Grant), 32'd1);
      chk("mg_count", 32'(Count), 32'd0);
      tick(4'b0000, 32'h0, 1'b0, 1'b1);
      chk("mg_clr", 32'(Err_Multi_Grant), 32'd0);
      tick(4'b0011, 32'h44332211, 1'b0, 1'b1);
      chk("mg_win", 32'(Err_Multi_Grant), 32'd1);
      tick(4'b0000, 32'h0, 1'b0, 1'b1);

      // head stability under stall while grants keep arriving
      tick(4'b0010, 32'hDDCCBBAA, 1'b0, 1'b0);
      chk_head("st0", 8'hBB, 2'd1);
      for (int k = 0; k < 5; k++) begin
         tick(stab_g[k], 32'hDDCCBBAA, 1'b0, 1'b0);
         chk_head("st", 8'hBB, 2'd1);
      end
      chk("st_ovf", 32'(Err_Overflow), 32'd1);
      tick(4'b0000, 32'h0, 1'b1, 1'b0);
      chk_head("st_pop", 8'hAA, 2'd0);
      chk("st_count", 32'(Count), 32'd3);

      // reset in the middle of a cycle with an Ack in flight
      tick(4'b0001, 32'h000000E1, 1'b1, 1'b0);
      chk("pre_rst_count", 32'(Count), 32'd3);
      chk("pre_rst_ack", 32'(Ack), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(Out_Valid), 32'd0);
      chk("mid_rst_count", 32'(Count), 32'd0);
      chk("mid_rst_ack", 32'(Ack), 32'd0);
      chk("mid_rst_eo", 32'(Err_Overflow), 32'd0);
      chk("mid_rst_em", 32'(Err_Multi_Grant), 32'd0);
      Grant = '0; Out_Ready = 1'b0; Err_Clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick(4'b1000, 32'h7E000000, 1'b0, 1'b0);
      chk_head("post_rst", 8'h7E, 2'd3);
      chk("post_rst_ack", 32'(Ack), 32'b1000);
      tick(4'b0000, 32'h0, 1'b1, 1'b0);
      chk("final_empty", 32'(Count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/arb_grant_fifo.md
Name: arb_grant_fifo

Overview:
- Downstream consumer of the 4-requester round-robin arbiter.
- Each cycle it samples the arbiter's one-hot Grant and captures the granted requester's data word plus its 2-bit requester ID into a small FIFO.
- It presents FIFO entries to a shared slave over a valid/ready interface.
- It returns a one-cycle Ack pulse to the requester whose grant was accepted.
- It flags protocol violations (multi-hot grant, overflow) with sticky error bits.

Parameters:
- DW, 8, data width per requester.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Grant  in  4  one-hot grant from the arbiter; bit i = requester i.
- Req_Data  in  4*DW  requester data, flattened; requester i occupies bits [i*DW +: DW].
- Out_Valid  out  1  FIFO head valid to the slave.
- Out_Ready  in  1  slave accepts the head this cycle.
- Out_Data  out  DW  head data.
- Out_Id  out  2  head requester ID.
- Ack  out  4  one-cycle pulse; bit i means requester i's grant was stored.
- Count  out  clog2(DEPTH)+1  current occupancy.
- Full  out  1  Count == DEPTH.
- Err_Multi_Grant  out  1  sticky; Grant had more than one bit set.
- Err_Overflow  out  1  sticky; a grant was dropped because the FIFO was full.
- Err_Clr  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (rst_n low, async): storage pointers, Count, Out_Valid, Ack, Full and both errors go to 0. Pending entries are discarded. Out_Data/Out_Id contents are don't-care but must not be flagged valid.
- Grant classification per posedge:
  - zero: no action.
  - one-hot: push request.
  - multi-hot: no push, no Ack; Err_Multi_Grant set on that edge.
- Pop: Out_Valid && Out_Ready at a posedge removes the head.
- Push acceptance: accepted if Count < DEPTH, or Count == DEPTH with a pop on the same edge (simultaneous push/pop when full is legal; Count unchanged).
- Dropped push: Err_Overflow set, no Ack, Count unchanged.
- Stored entry: {ID = index of the set Grant bit, Req_Data slice of that requester sampled at the same edge}.
- Ack latency: push accepted at edge N gives Ack[i] = 1 for the cycle after edge N only, then 0. Ack is zero in all other cycles and is at most one-hot.
- Output: first-word-fall-through. An entry pushed into an empty FIFO at edge N drives Out_Valid = 1 and Out_Data/Out_Id from edge N onward. Out_Valid = (Count != 0).
- Stability: while Out_Valid && !Out_Ready, Out_Data and Out_Id hold stable.
- Ordering: entries leave in grant order.
- Pointers: wrap modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH, never underflows. A pop on empty is impossible because Out_Valid = 0.
- Error clear: Err_Clr at an edge clears both errors. If an error event and Err_Clr occur on the same edge, the error wins (stays 1).
- Reset mid-transfer: the FIFO empties immediately, and Out_Valid and Ack drop asynchronously.

Test Plan:
- Reset, then Grant=0001 with Req_Data[7:0]=0xA5, Out_Ready=0 -> next cycle Ack=0001, Out_Valid=1, Out_Data=0xA5, Out_Id=0, Count=1.
- Grants 0001, 0010, 0100, 1000 on consecutive edges (data 0x10..0x13), Out_Ready=0 -> Count=4, Full=1; Out_Ready=1 then drains 0x10/0,0x11/1,0x12/2,0x13/3 in order.
- FIFO full, Out_Ready=0, Grant=0100 -> no Ack, Err_Overflow=1, Count stays 4. Repeat with Out_Ready=1 on the same edge -> push accepted, Ack=0100, Count stays 4, no error.
- Grant=0011 -> no push, Ack=0, Err_Multi_Grant=1. Err_Clr pulse -> error 0. Err_Clr coincident with another 0011 -> error remains 1.
- Out_Valid=1, Out_Ready=0 for 5 cycles while new grants arrive -> Out_Data/Out_Id unchanged until the pop edge.
- Count=3, rst_n asserted mid-cycle -> Out_Valid, Count, Ack and errors are 0 immediately. After release, Grant=1000 with data 0x7E -> Out_Data=0x7E, Out_Id=3.
